sa_ram_rwsp_fifo_ctrl: RTL and testbench

// - Sequences one external sa_ram_rwsp_32x256-class two-port RAM as a valid/ready FIFO.
// - Drives ra/re/ore/wa/we/di and hides the 2-stage read pipeline (re registers the address, ore registers dout).
// - Sits between a producer and a consumer on the small-config datapath, e.g. a CDMA-to-CBUF staging buffer.
// - The RAM stays a separate instance; this block holds pointers, counters and pipeline valids only.

---
 rtl/sa_fifo_pkg.sv | 7 +
 rtl/sa_ram_rwsp_32x256.sv | 24 ++
 rtl/sa_ram_rwsp_fifo_ctrl.sv | 89 ++++++++
 tb/tb_sa_ram_rwsp_fifo_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_fifo_pkg.sv
// Shared sizing for the RAM-backed staging FIFO and its RAM.
package sa_fifo_pkg;
  localparam int FIFO_DEPTH = 32;
  localparam int FIFO_AW    = 5;
  localparam int FIFO_DW    = 256;
  localparam int CNT_W      = FIFO_AW + 1;
endpackage

// File: rtl/sa_ram_rwsp_32x256.sv
// Two-port RAM: read address is registered on re, output data is registered on ore.
module sa_ram_rwsp_32x256
  import sa_fifo_pkg::*;
(
  input  logic               clk,
  input  logic [FIFO_AW-1:0] ra,
  input  logic               re,
  input  logic               ore,
  output logic [FIFO_DW-1:0] dout,
  input  logic [FIFO_AW-1:0] wa,
  input  logic               we,
  input  logic [FIFO_DW-1:0] di
);

  logic [FIFO_DW-1:0] mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] ra_d;

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= di;
    if (re) ra_d <= ra;
    if (ore) dout <= mem[ra_d];
  end

endmodule

// File: rtl/sa_ram_rwsp_fifo_ctrl.sv
// Valid/ready FIFO sequencer for an external two-stage-read RAM; holds pointers,
// occupancy and the two pipeline-valid flags only.
module sa_ram_rwsp_fifo_ctrl
  import sa_fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = FIFO_AW,
  parameter int DW    = FIFO_DW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic [AW-1:0] ram_wa,
  output logic          ram_we,
  output logic [DW-1:0] ram_di,
  output logic [AW-1:0] ram_ra,
  output logic          ram_re,
  output logic          ram_ore,
  input  logic [DW-1:0] ram_dout,
  output logic [AW:0]   count
);

  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] pend_q, pend_d;
  logic          s1_vld_q, s1_vld_d;
  logic          s2_vld_q, s2_vld_d;
  logic          rd_acc;

  // Enables are all combinational from rd_prdy so the pipeline streams one word per cycle.
  always_comb begin
    wr_prdy = rstn && !clr && (count_q != CW'(DEPTH));
    ram_we  = wr_pvld && wr_prdy;
    ram_ore = s1_vld_q && (!s2_vld_q || rd_prdy);
    ram_re  = (pend_q != '0) && (!s1_vld_q || ram_ore) && !clr;
    rd_acc  = s2_vld_q && rd_prdy;

    wr_ptr_d = wr_ptr_q + AW'(ram_we);
    rd_ptr_d = rd_ptr_q + AW'(ram_re);
    count_d  = count_q + CW'(ram_we) - CW'(rd_acc);
    pend_d   = pend_q + CW'(ram_we) - CW'(ram_re);
    s1_vld_d = ram_re ? 1'b1 : (ram_ore ? 1'b0 : s1_vld_q);
    s2_vld_d = ram_ore || (s2_vld_q && !rd_prdy);

    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      pend_d   = '0;
      s1_vld_d = 1'b0;
      s2_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
    end
  end

  assign rd_pvld = s2_vld_q;
  assign rd_pd   = ram_dout;
  assign ram_wa  = wr_ptr_q;
  assign ram_di  = wr_pd;
  assign ram_ra  = rd_ptr_q;
  assign count   = count_q;

endmodule

// File: tb/tb_sa_ram_rwsp_fifo_ctrl.sv
// Self-checking bench: FIFO controller plus RAM model against a queue-based reference.
module tb_sa_ram_rwsp_fifo_ctrl;
  import sa_fifo_pkg::*;

  logic               clk = 1'b0;
  logic               rstn, clr, wr_pvld, wr_prdy, rd_pvld, rd_prdy;
  logic [FIFO_DW-1:0] wr_pd, rd_pd, ram_di, ram_dout;
  logic [FIFO_AW-1:0] ram_wa, ram_ra;
  logic               ram_we, ram_re, ram_ore;
  logic [FIFO_AW:0]   count;

  int                 checks = 0;
  int                 errors = 0;
  int                 reads  = 0;
  logic [FIFO_DW-1:0] model_q[$];
  logic               hold_pending = 1'b0;
  logic [FIFO_DW-1:0] hold_pd;

  always #5 clk = ~clk;

  sa_ram_rwsp_fifo_ctrl dut (
    .clk(clk), .rstn(rstn), .clr(clr),
    .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
    .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
    .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
    .ram_ra(ram_ra), .ram_re(ram_re), .ram_ore(ram_ore),
    .ram_dout(ram_dout), .count(count)
  );

  sa_ram_rwsp_32x256 u_ram (
    .clk(clk), .ra(ram_ra), .re(ram_re), .ore(ram_ore), .dout(ram_dout),
    .wa(ram_wa), .we(ram_we), .di(ram_di)
  );

  function automatic logic [FIFO_DW-1:0] rand_word();
    logic [FIFO_DW-1:0] w;
    for (int k = 0; k < FIFO_DW / 32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  // One cycle against the reference queue: drive at negedge, check before the next posedge.
  task automatic step(input logic wv, input logic [FIFO_DW-1:0] d, input logic rr,
                      output logic wacc);
    logic               exp_prdy;
    logic [FIFO_DW-1:0] exp_pd;
    @(negedge clk);
    wr_pvld = wv; wr_pd = d; rd_prdy = rr; clr = 1'b0;
    #1;
    exp_prdy = (model_q.size() != FIFO_DEPTH);
    checks++;
    if (count !== 7'(model_q.size()) >> 0 && count !== (FIFO_AW+1)'(model_q.size())) begin
      errors++;
      $display("[TB] FAIL count: got %0d expected %0d", count, model_q.size());
    end
    checks++;
    if (wr_prdy !== exp_prdy) begin
      errors++;
      $display("[TB] FAIL wr_prdy: got %b expected %b", wr_prdy, exp_prdy);
    end
    checks++;
    if (rd_pvld !== 1'b0 && model_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL rd_pvld_empty: got %b expected 0", rd_pvld);
    end
    if (hold_pending) begin
      checks++;
      if (rd_pvld !== 1'b1 || rd_pd !== hold_pd) begin
        errors++;
        $display("[TB] FAIL stall_hold: got vld=%b pd=%h expected vld=1 pd=%h",
                 rd_pvld, rd_pd, hold_pd);
      end
    end
    hold_pending = (rd_pvld === 1'b1) && !rr;
    hold_pd      = rd_pd;
    if (rd_pvld === 1'b1 && rr && model_q.size() != 0) begin
      exp_pd = model_q.pop_front();
      reads++;
      checks++;
      if (rd_pd !== exp_pd) begin
        errors++;
        $display("[TB] FAIL rd_pd: got %h expected %h", rd_pd, exp_pd);
      end
    end
    wacc = wv && exp_prdy;
    checks++;
    if (ram_we !== wacc) begin
      errors++;
      $display("[TB] FAIL ram_we: got %b expected %b", ram_we, wacc);
    end
    if (wacc) model_q.push_back(d);
  endtask

  task automatic send_word(input logic [FIFO_DW-1:0] d, input logic rr);
    logic acc = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) step(1'b1, d, rr, acc);
    checks++;
    if (!acc) begin
      errors++;
      $display("[TB] FAIL send_timeout: got no accept expected accept");
    end
  endtask

  task automatic drain();
    logic acc;
    for (int n = 0; n < 300 && model_q.size() != 0; n++) step(1'b0, '0, 1'b1, acc);
    checks++;
    if (model_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d left expected 0", model_q.size());
    end
    repeat (2) step(1'b0, '0, 1'b1, acc);
  endtask

  task automatic test_reset();
    rstn = 1'b0; clr = 1'b0; wr_pvld = 1'b1; wr_pd = rand_word(); rd_prdy = 1'b1;
    repeat (2) begin
      @(negedge clk); #1;
      checks++;
      if (ram_we !== 1'b0 || rd_pvld !== 1'b0 || count !== '0 || wr_prdy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_state: got we=%b vld=%b cnt=%0d prdy=%b expected 0 0 0 0",
                 ram_we, rd_pvld, count, wr_prdy);
      end
    end
    @(negedge clk); rstn = 1'b1; wr_pvld = 1'b0; #1;
    checks++;
    if (wr_prdy !== 1'b1 || ram_re !== 1'b0 || ram_ore !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release: got prdy=%b re=%b ore=%b expected 1 0 0",
               wr_prdy, ram_re, ram_ore);
    end
    model_q.delete(); hold_pending = 1'b0;
  endtask

  // Fixed-latency check for one word into an empty FIFO.
  task automatic test_single(input logic [FIFO_DW-1:0] d);
    @(negedge clk); wr_pvld = 1'b1; wr_pd = d; rd_prdy = 1'b1; clr = 1'b0; #1;
    checks++;
    if (ram_we !== 1'b1) begin
      errors++; $display("[TB] FAIL single_we: got %b expected 1", ram_we);
    end
    @(negedge clk); wr_pvld = 1'b0; #1;
    checks++;
    if (ram_re !== 1'b1 || rd_pvld !== 1'b0 || count !== 6'd1) begin
      errors++;
      $display("[TB] FAIL single_e1: got re=%b vld=%b cnt=%0d expected 1 0 1", ram_re, rd_pvld, count);
    end
    @(negedge clk); #1;
    checks++;
    if (ram_ore !== 1'b1 || rd_pvld !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_e2: got ore=%b vld=%b expected 1 0", ram_ore, rd_pvld);
    end
    @(negedge clk); #1;
    checks++;
    if (rd_pvld !== 1'b1 || rd_pd !== d) begin
      errors++;
      $display("[TB] FAIL single_data: got vld=%b pd=%h expected 1 %h", rd_pvld, rd_pd, d);
    end
    @(negedge clk); #1;
    checks++;
    if (rd_pvld !== 1'b0 || count !== '0) begin
      errors++;
      $display("[TB] FAIL single_after: got vld=%b cnt=%0d expected 0 0", rd_pvld, count);
    end
  endtask

  task automatic test_fill_wrap();
    logic acc;
    int   start_reads = reads;
    for (int i = 0; i < 32; i++) send_word(FIFO_DW'(i), 1'b0);
    step(1'b0, '0, 1'b0, acc);
    checks++;
    if (count !== 6'd32 || wr_prdy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fill_full: got cnt=%0d prdy=%b expected 32 0", count, wr_prdy);
    end
    for (int i = 32; i < 64; i++) send_word(FIFO_DW'(i), 1'b1);
    drain();
    checks++;
    if (reads - start_reads != 64) begin
      errors++;
      $display("[TB] FAIL wrap_reads: got %0d expected 64", reads - start_reads);
    end
  endtask

  task automatic test_back_pressure();
    logic acc;
    int   sent = 0;
    int   cyc  = 0;
    logic [FIFO_DW-1:0] w = rand_word();
    while (sent < 40 && cyc < 400) begin
      step(1'b1, w, (cyc % 4 == 0) || (cyc % 4 == 3), acc);
      if (acc) begin sent++; w = rand_word(); end
      cyc++;
    end
    checks++;
    if (sent != 40) begin
      errors++; $display("[TB] FAIL bp_sent: got %0d expected 40", sent);
    end
    for (int n = 0; n < 400 && model_q.size() != 0; n++) begin
      step(1'b0, '0, (cyc % 4 == 0) || (cyc % 4 == 3), acc);
      cyc++;
    end
    drain();
  endtask

  task automatic test_simultaneous();
    logic acc;
    for (int i = 0; i < 31; i++) send_word(rand_word(), 1'b0);
    repeat (3) step(1'b0, '0, 1'b0, acc);
    step(1'b1, rand_word(), 1'b1, acc);
    @(negedge clk); wr_pvld = 1'b0; rd_prdy = 1'b0; #1;
    checks++;
    if (count !== 6'd31) begin
      errors++; $display("[TB] FAIL simul_31: got %0d expected 31", count);
    end
    send_word(rand_word(), 1'b0);
    repeat (2) step(1'b0, '0, 1'b0, acc);
    step(1'b1, rand_word(), 1'b1, acc);
    @(negedge clk); wr_pvld = 1'b0; rd_prdy = 1'b0; #1;
    checks++;
    if (count !== 6'd31) begin
      errors++; $display("[TB] FAIL simul_full: got %0d expected 31", count);
    end
    drain();
  endtask

  task automatic test_flush();
    logic acc;
    for (int i = 0; i < 10; i++) send_word(rand_word(), 1'b0);
    repeat (3) step(1'b0, '0, 1'b0, acc);
    @(negedge clk); clr = 1'b1; wr_pvld = 1'b1; wr_pd = rand_word(); rd_prdy = 1'b1; #1;
    checks++;
    if (wr_prdy !== 1'b0 || ram_we !== 1'b0 || ram_re !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_gate: got prdy=%b we=%b re=%b expected 0 0 0", wr_prdy, ram_we, ram_re);
    end
    @(negedge clk); clr = 1'b0; wr_pvld = 1'b0; rd_prdy = 1'b0; #1;
    checks++;
    if (rd_pvld !== 1'b0 || count !== '0) begin
      errors++;
      $display("[TB] FAIL flush_state: got vld=%b cnt=%0d expected 0 0", rd_pvld, count);
    end
    model_q.delete(); hold_pending = 1'b0;
    test_single(rand_word());
  endtask

  task automatic test_random();
    logic acc;
    for (int n = 0; n < 300; n++)
      step($urandom_range(0, 2) != 0, rand_word(), $urandom_range(0, 3) != 0, acc);
    drain();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) send_word(rand_word(), 1'b0);
    @(negedge clk); rstn = 1'b0; wr_pvld = 1'b0; rd_prdy = 1'b0;
    @(negedge clk); rstn = 1'b1; #1;
    checks++;
    if (count !== '0 || rd_pvld !== 1'b0 || wr_prdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid: got cnt=%0d vld=%b prdy=%b expected 0 0 1", count, rd_pvld, wr_prdy);
    end
    model_q.delete(); hold_pending = 1'b0;
    test_single({32{8'h3C}});
  endtask

  initial begin
    test_reset();
    test_single({32{8'hA5}});
    test_fill_wrap();
    test_back_pressure();
    test_simultaneous();
    test_flush();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
